// File: rtl/fp_real2bcd.sv
// Purpose: converts the unsigned integer and fraction fields of a real number to packed BCD (double-dabble).
// Latency: out_valid rises WIDTH clocks after the accepting edge; one conversion per WIDTH+2 clocks at best.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready, and inputs are ignored while busy.
module fp_real2bcd #(
  parameter int WIDTH  = 24,
  parameter int DIGITS = 8,
  parameter int CNT_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [WIDTH-1:0]      in_pre,
  input  logic [WIDTH-1:0]      in_significand,
  input  logic [4:0]            in_point,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [4*DIGITS-1:0]   out_int_bcd,
  output logic [4*DIGITS-1:0]   out_frac_bcd,
  output logic [4:0]            out_point
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     r_bin_int;
  logic [WIDTH-1:0]     r_bin_frac;
  logic [4*DIGITS-1:0]  r_bcd_int;
  logic [4*DIGITS-1:0]  r_bcd_frac;
  logic                 r_sign;
  logic [4:0]           r_point;
  logic                 r_out_sign;
  logic [4*DIGITS-1:0]  r_out_int;
  logic [4*DIGITS-1:0]  r_out_frac;
  logic [4:0]           r_out_point;

  logic [4*DIGITS-1:0]  w_int_adj;
  logic [4*DIGITS-1:0]  w_frac_adj;
  logic [4*DIGITS-1:0]  w_int_nxt;
  logic [4*DIGITS-1:0]  w_frac_nxt;
  logic                 w_last;

  // Per-digit +3 correction; digits are independent, no carry between them.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] bcd);
    logic [4*DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    return res;
  endfunction

  // Correction happens before the shift within the same cycle; the next binary MSB enters digit 0.
  assign w_int_adj  = add3(r_bcd_int);
  assign w_frac_adj = add3(r_bcd_frac);
  assign w_int_nxt  = {w_int_adj[4*DIGITS-2:0], r_bin_int[WIDTH-1]};
  assign w_frac_nxt = {w_frac_adj[4*DIGITS-2:0], r_bin_frac[WIDTH-1]};
  assign w_last     = (r_cnt == CNT_W'(1));

  assign in_ready     = (r_state == S_IDLE);
  assign out_valid    = (r_state == S_DONE);
  assign out_sign     = r_out_sign;
  assign out_int_bcd  = r_out_int;
  assign out_frac_bcd = r_out_frac;
  assign out_point    = r_out_point;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state: accept in IDLE, iterate WIDTH times, hold until the result is taken.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last)    w_state_nxt = S_DONE;
      S_DONE:  if (out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: load on accept, shift each SHIFT cycle, publish on the last shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_bin_int   <= '0;
      r_bin_frac  <= '0;
      r_bcd_int   <= '0;
      r_bcd_frac  <= '0;
      r_sign      <= 1'b0;
      r_point     <= '0;
      r_out_sign  <= 1'b0;
      r_out_int   <= '0;
      r_out_frac  <= '0;
      r_out_point <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin_int  <= in_pre;
            r_bin_frac <= in_significand;
            r_bcd_int  <= '0;
            r_bcd_frac <= '0;
            r_sign     <= in_sign;
            r_point    <= in_point;
            r_cnt      <= CNT_W'(WIDTH);
          end
        end
        S_SHIFT: begin
          r_bcd_int  <= w_int_nxt;
          r_bcd_frac <= w_frac_nxt;
          r_bin_int  <= {r_bin_int[WIDTH-2:0], 1'b0};
          r_bin_frac <= {r_bin_frac[WIDTH-2:0], 1'b0};
          r_cnt      <= r_cnt - CNT_W'(1);
          if (w_last) begin
            r_out_int   <= w_int_nxt;
            r_out_frac  <= w_frac_nxt;
            r_out_sign  <= r_sign;
            r_out_point <= r_point;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
